// File: rtl/vscpu_core_param.sv
// rtl/vscpu_core_param.sv - multi-cycle memory-to-memory VerySimple CPU core, req/ack bus
// Optional multiplier for MUL/MULi enabled by defining VSCPU_MUL_EN.
module vscpu_core_param #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic              retire
);

  localparam int IW_W = 2*ADDR_W + 4;
  localparam logic [DATA_W-1:0] DW_VAL = DATA_W'(DATA_W);

  localparam logic [3:0] OP_ADDI = 4'd1, OP_NANDI = 4'd3, OP_SRLI = 4'd5, OP_LTI = 4'd7;
  localparam logic [3:0] OP_CP = 4'd8, OP_CPi = 4'd9, OP_CPI = 4'd10, OP_CPIi = 4'd11;
  localparam logic [3:0] OP_BZJ = 4'd12, OP_BZJi = 4'd13, OP_MUL = 4'd14, OP_MULi = 4'd15;

  if (DATA_W < 4 + 2*ADDR_W) begin : g_width_check
    $error("vscpu_core_param: DATA_W must be at least 4+2*ADDR_W");
  end

  typedef enum logic [2:0] {FETCH, RD_A, RD_B, RD_I, WRITE, HALT, SKIP} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n, pc_inc, target;
  logic [IW_W-1:0]     iw, iw_n;
  logic [DATA_W-1:0]   a_val, a_val_n, wdata_n;
  logic [ADDR_W-1:0]   addr_n;
  logic                req_n, we_n, halted_n, retire_n, do_retire, ack;
  logic [3:0]          op, r_op;
  logic [ADDR_W-1:0]   f_a, f_b, r_a, r_b;

  assign op     = iw[IW_W-1 -: 4];
  assign f_a    = iw[2*ADDR_W-1 -: ADDR_W];
  assign f_b    = iw[ADDR_W-1:0];
  assign r_op   = mem_rdata[IW_W-1 -: 4];
  assign r_a    = mem_rdata[2*ADDR_W-1 -: ADDR_W];
  assign r_b    = mem_rdata[ADDR_W-1:0];
  assign pc_inc = pc + 1'b1;
  assign ack    = mem_req & mem_ack;

  function automatic logic [DATA_W-1:0] zext(input logic [ADDR_W-1:0] v);
    return {{(DATA_W-ADDR_W){1'b0}}, v};
  endfunction

  // Opcode bits [3:1] select the operation; bit 0 only picks *B versus the immediate.
  function automatic logic [DATA_W-1:0] alu(input logic [2:0] grp,
                                            input logic [DATA_W-1:0] x,
                                            input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] r;
    r = '0;
    case (grp)
      3'd0: r = x + y;
      3'd1: r = ~(x & y);
      3'd2: r = (y < DW_VAL) ? (x >> y) : (x << (y - DW_VAL));
      3'd3: r = {{(DATA_W-1){1'b0}}, (x < y)};
`ifdef VSCPU_MUL_EN
      3'd7: r = x * y;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= '0;
      iw        <= '0;
      a_val     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      retire    <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      iw        <= iw_n;
      a_val     <= a_val_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      halted    <= halted_n;
      retire    <= retire_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    iw_n      = iw;
    a_val_n   = a_val;
    req_n     = mem_req;
    we_n      = mem_we;
    addr_n    = mem_addr;
    wdata_n   = mem_wdata;
    halted_n  = halted;
    retire_n  = 1'b0;
    do_retire = 1'b0;
    target    = pc_inc;
    case (state)
      FETCH: begin
        // Request is low in FETCH only straight after reset; retirement pre-issues later fetches.
        if (!mem_req) begin
          req_n  = 1'b1;
          we_n   = 1'b0;
          addr_n = pc;
        end else if (mem_ack) begin
          iw_n = mem_rdata[IW_W-1:0];
          case (r_op)
            OP_CP, OP_CPI: begin state_n = RD_B; addr_n = r_b; end
            OP_CPi: begin
              state_n = WRITE; addr_n = r_a; we_n = 1'b1; wdata_n = zext(r_b);
            end
`ifndef VSCPU_MUL_EN
            OP_MUL, OP_MULi: begin state_n = SKIP; req_n = 1'b0; end
`endif
            default: begin state_n = RD_A; addr_n = r_a; end
          endcase
        end
      end
      RD_A: if (ack) begin
        a_val_n = mem_rdata;
        case (op)
          OP_BZJi: begin do_retire = 1'b1; target = mem_rdata[ADDR_W-1:0] + f_b; end
          OP_ADDI, OP_NANDI, OP_SRLI, OP_LTI, OP_MULi: begin
            state_n = WRITE; addr_n = f_a; we_n = 1'b1;
            wdata_n = alu(op[3:1], mem_rdata, zext(f_b));
          end
          default: begin state_n = RD_B; addr_n = f_b; end
        endcase
      end
      RD_B: if (ack) begin
        case (op)
          OP_CPI: begin state_n = RD_I; addr_n = mem_rdata[ADDR_W-1:0]; end
          OP_CPIi: begin
            state_n = WRITE; addr_n = a_val[ADDR_W-1:0]; we_n = 1'b1; wdata_n = mem_rdata;
          end
          OP_CP: begin state_n = WRITE; addr_n = f_a; we_n = 1'b1; wdata_n = mem_rdata; end
          OP_BZJ: begin
            do_retire = 1'b1;
            target    = (mem_rdata == '0) ? a_val[ADDR_W-1:0] : pc_inc;
          end
          default: begin
            state_n = WRITE; addr_n = f_a; we_n = 1'b1;
            wdata_n = alu(op[3:1], a_val, mem_rdata);
          end
        endcase
      end
      RD_I: if (ack) begin
        state_n = WRITE; addr_n = f_a; we_n = 1'b1; wdata_n = mem_rdata;
      end
      WRITE: if (ack) do_retire = 1'b1;
      SKIP: do_retire = 1'b1;
      HALT: ;
      default: state_n = FETCH;
    endcase

    // Only a branch can produce target==pc, so this is the self-loop halt detector.
    if (do_retire) begin
      pc_n     = target;
      retire_n = 1'b1;
      we_n     = 1'b0;
      if (target == pc) begin
        state_n  = HALT;
        halted_n = 1'b1;
        req_n    = 1'b0;
      end else begin
        state_n = FETCH;
        req_n   = 1'b1;
        addr_n  = target;
      end
    end
  end

endmodule

// File: tb/tb_vscpu_core_param.sv
// tb/tb_vscpu_core_param.sv - directed self-checking bench for vscpu_core_param
module tb_vscpu_core_param;
  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req, mem_we, halted, retire;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int waits = 0, wcnt = 0, stab_err = 0;
  int passed = 0, total = 0;

  vscpu_core_param #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halted(halted), .retire(retire)
  );

  always #5 clk = ~clk;

  // RAM model: completes writes on the ack edge, then presents ack/rdata just after the edge.
  always begin
    @(posedge clk);
    if (rst) wcnt = 0;
    else if (mem_req && mem_ack) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      wcnt = 0;
    end else if (mem_req) wcnt++;
    else wcnt = 0;
    #1;
    mem_ack   = mem_req && (wcnt >= waits);
    mem_rdata = mem[mem_addr];
  end

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [13:0] a, input logic [13:0] b);
    return {op, a, b};
  endfunction

  task automatic start_reset(input int w);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    waits = w;
    stab_err = 0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
  endtask

  task automatic run_instr(output int cycles);
    logic p_req, p_ack, p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wd;
    cycles = -1; p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (retire) begin cycles = n; break; end
      if (p_req && !p_ack && mem_req &&
          (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wd)) stab_err++;
      p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
    end
  endtask

  task automatic test_reset;
    start_reset(0);
    total++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL reset_we: got %b want 0", mem_we); else passed++;
    total++; if (mem_addr !== '0) $display("FAIL reset_addr: got %0h want 0", mem_addr); else passed++;
    total++; if (mem_wdata !== '0) $display("FAIL reset_wdata: got %0h want 0", mem_wdata); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else passed++;
    total++; if (retire !== 1'b0) $display("FAIL reset_retire: got %b want 0", retire); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== '0)
      $display("FAIL first_fetch: got req=%b addr=%0h want req=1 addr=0", mem_req, mem_addr); else passed++;
  endtask

  task automatic test_add(input int w, input int exp_cyc);
    int c;
    start_reset(w);
    mem[0] = ins(4'd0, 14'd100, 14'd101); mem[100] = 7; mem[101] = 5;
    rst = 1'b0;
    run_instr(c);
    total++; if (c !== exp_cyc) $display("FAIL add_cycles(w=%0d): got %0d want %0d", w, c, exp_cyc); else passed++;
    total++; if (mem[100] !== 32'd12) $display("FAIL add_result(w=%0d): got %0d want 12", w, mem[100]); else passed++;
    total++; if (mem_addr !== 14'd1 || mem_req !== 1'b1)
      $display("FAIL add_pc(w=%0d): got req=%b addr=%0d want req=1 addr=1", w, mem_req, mem_addr); else passed++;
    total++; if (stab_err !== 0) $display("FAIL add_stable(w=%0d): got %0d changes want 0", w, stab_err); else passed++;
    @(negedge clk);
    total++; if (retire !== 1'b0) $display("FAIL add_retire_once(w=%0d): got %b want 0", w, retire); else passed++;
  endtask

  task automatic test_shift;
    int c;
    start_reset(0);
    mem[0] = ins(4'd5, 14'd100, 14'd31);
    mem[1] = ins(4'd5, 14'd101, 14'd33);
    mem[2] = ins(4'd5, 14'd102, 14'd70);
    mem[3] = ins(4'd4, 14'd103, 14'd104);
    mem[100] = 32'h8000_0000; mem[101] = 32'h8000_0000; mem[102] = 32'h8000_0000;
    mem[103] = 32'h1; mem[104] = 32'd33;
    rst = 1'b0;
    repeat (4) run_instr(c);
    total++; if (mem[100] !== 32'h1) $display("FAIL srli_31: got %0h want 1", mem[100]); else passed++;
    total++; if (mem[101] !== 32'h0) $display("FAIL srli_33: got %0h want 0", mem[101]); else passed++;
    total++; if (mem[102] !== 32'h0) $display("FAIL srli_70: got %0h want 0", mem[102]); else passed++;
    total++; if (mem[103] !== 32'h2) $display("FAIL srl_33_left: got %0h want 2", mem[103]); else passed++;
  endtask

  task automatic test_alu;
    int c;
    start_reset(0);
    mem[0] = ins(4'd9,  14'd103, 14'd77);
    mem[1] = ins(4'd3,  14'd100, 14'h0F);
    mem[2] = ins(4'd6,  14'd101, 14'd102);
    mem[3] = ins(4'd1,  14'd104, 14'h3FFF);
    mem[4] = ins(4'd2,  14'd105, 14'd106);
    mem[5] = ins(4'd7,  14'd107, 14'd3);
    mem[100] = 32'hFFFF_FFF0; mem[101] = 3; mem[102] = 32'hFFFF_FFFF;
    mem[104] = 1; mem[105] = 32'hF0F0_F0F0; mem[106] = 32'hFF00_FF00; mem[107] = 3;
    rst = 1'b0;
    run_instr(c);
    total++; if (c !== 2) $display("FAIL cpi_cycles: got %0d want 2", c); else passed++;
    total++; if (mem[103] !== 32'd77) $display("FAIL cpi_imm: got %0d want 77", mem[103]); else passed++;
    repeat (5) run_instr(c);
    total++; if (mem[100] !== 32'hFFFF_FFFF) $display("FAIL nandi: got %0h want ffffffff", mem[100]); else passed++;
    total++; if (mem[101] !== 32'd1) $display("FAIL lt_unsigned: got %0d want 1", mem[101]); else passed++;
    total++; if (mem[104] !== 32'h4000) $display("FAIL addi: got %0h want 4000", mem[104]); else passed++;
    total++; if (mem[105] !== 32'h0FFF_0FFF) $display("FAIL nand: got %0h want 0fff0fff", mem[105]); else passed++;
    total++; if (mem[107] !== 32'd0) $display("FAIL lti_equal: got %0d want 0", mem[107]); else passed++;
  endtask

  task automatic test_indirect;
    int c;
    start_reset(0);
    mem[0] = ins(4'd10, 14'd200, 14'd201);
    mem[1] = ins(4'd11, 14'd210, 14'd211);
    mem[201] = 300; mem[300] = 32'hDEAD; mem[210] = 400; mem[211] = 9;
    rst = 1'b0;
    run_instr(c);
    total++; if (c !== 4) $display("FAIL cpind_cycles: got %0d want 4", c); else passed++;
    total++; if (mem[200] !== 32'hDEAD) $display("FAIL cpind: got %0h want dead", mem[200]); else passed++;
    run_instr(c);
    total++; if (mem[400] !== 32'd9) $display("FAIL cpindi: got %0d want 9", mem[400]); else passed++;
    total++; if (mem[210] !== 32'd400) $display("FAIL cpindi_ptr: got %0d want 400", mem[210]); else passed++;
  endtask

  task automatic test_branch_halt;
    int c;
    start_reset(0);
    mem[0] = ins(4'd12, 14'd50, 14'd51);
    mem[5] = ins(4'd13, 14'd52, 14'd5);
    mem[50] = 5; mem[51] = 0; mem[52] = 0;
    rst = 1'b0;
    run_instr(c);
    total++; if (mem_addr !== 14'd5 || halted !== 1'b0)
      $display("FAIL bzj_taken: got addr=%0d halted=%b want addr=5 halted=0", mem_addr, halted); else passed++;
    run_instr(c);
    total++; if (halted !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL bzji_halt: got halted=%b req=%b want halted=1 req=0", halted, mem_req); else passed++;
    repeat (3) @(negedge clk);
    total++; if (mem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1)
      $display("FAIL halt_hold: got req=%b retire=%b halted=%b want 0 0 1", mem_req, retire, halted); else passed++;
  endtask

  task automatic test_pc_wrap;
    int c;
    start_reset(0);
    mem[0] = ins(4'd12, 14'd50, 14'd51);
    mem[50] = 32'h3FFF; mem[51] = 0;
    mem[14'h3FFF] = ins(4'd9, 14'd300, 14'd1);
    rst = 1'b0;
    run_instr(c);
    total++; if (mem_addr !== 14'h3FFF) $display("FAIL wrap_jump: got %0h want 3fff", mem_addr); else passed++;
    run_instr(c);
    total++; if (mem_addr !== 14'd0 || mem[300] !== 32'd1)
      $display("FAIL wrap_pc: got addr=%0h mem300=%0d want addr=0 mem300=1", mem_addr, mem[300]); else passed++;
  endtask

  task automatic test_reset_mid;
    bit found;
    start_reset(2);
    mem[0] = ins(4'd0, 14'd100, 14'd101); mem[100] = 7; mem[101] = 5;
    rst = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 14'd101 && !mem_ack) begin found = 1'b1; break; end
    end
    total++; if (found !== 1'b1) $display("FAIL rdb_wait_seen: got %b want 1", found); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (mem_req !== 1'b0) $display("FAIL reset_abandon: got req=%b want 0", mem_req); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== '0 || mem_we !== 1'b0)
      $display("FAIL reset_refetch: got req=%b addr=%0d we=%b want 1 0 0", mem_req, mem_addr, mem_we); else passed++;
    total++; if (mem[100] !== 32'd7) $display("FAIL reset_nowrite: got %0d want 7", mem[100]); else passed++;
  endtask

  task automatic test_mul;
    int c, exp_cyc;
    logic [DW-1:0] exp_i, exp_r;
`ifdef VSCPU_MUL_EN
    exp_cyc = 3; exp_i = 32'd42; exp_r = 32'h0001_0000;
`else
    exp_cyc = 2; exp_i = 32'd6; exp_r = 32'h0001_0000;
`endif
    start_reset(0);
    mem[0] = ins(4'd15, 14'd100, 14'd7);
    mem[1] = ins(4'd14, 14'd101, 14'd102);
    mem[100] = 6; mem[101] = 32'h0001_0000; mem[102] = 32'h0001_0001;
    rst = 1'b0;
    run_instr(c);
    total++; if (c !== exp_cyc) $display("FAIL muli_cycles: got %0d want %0d", c, exp_cyc); else passed++;
    total++; if (mem[100] !== exp_i) $display("FAIL muli: got %0d want %0d", mem[100], exp_i); else passed++;
    total++; if (mem_addr !== 14'd1) $display("FAIL muli_pc: got %0d want 1", mem_addr); else passed++;
    run_instr(c);
    total++; if (mem[101] !== exp_r) $display("FAIL mul: got %0h want %0h", mem[101], exp_r); else passed++;
    total++; if (mem_addr !== 14'd2) $display("FAIL mul_pc: got %0d want 2", mem_addr); else passed++;
  endtask

  initial begin
    test_reset;
    test_add(0, 4);
    test_add(2, 12);
    test_shift;
    test_alu;
    test_indirect;
    test_branch_halt;
    test_pc_wrap;
    test_reset_mid;
    test_mul;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
